wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the register file. Collects results from NUM_SRC
//  execution sources (0=ALU, 1=MUL, 2=MEM) and buffers them in per-source FIFOs. Grants one
//  result per cycle and drives the register-file write port (writeEn/dest_addr/writeVal) and
//  its exception capture port (xcpt_valid/rmPC/rmAddr).
// PARAMETERS
//  NUM_SRC      3  number of result sources; index = static priority, higher index wins
//  FIFO_DEPTH   2  entries per source FIFO; power of two, >=2
//  STARVE_LIMIT 8  consecutive lost-arbitration cycles before a source is forced to win
// PORTS
//  clock         in   1                   system clock
//  reset         in   1                   asynchronous, active-low reset
//  flush         in   1                   pipeline flush; discards buffered results
//  src_valid     in   NUM_SRC             source result valid
//  src_ready     out  NUM_SRC             source FIFO not full
//  src_dest      in   NUM_SRC x REG_ADDR  destination register per source
//  src_data      in   NUM_SRC x REG_DATA  result value per source
//  src_xcpt      in   NUM_SRC             result carries an exception
//  src_pc        in   NUM_SRC x PC_WIDTH  PC of the excepting instruction
//  src_xaddr     in   NUM_SRC x XCPT_ADDR faulting address / cause
//  writeEn       out  1                   register-file write enable (registered)
//  dest_addr     out  REG_ADDR            write address (registered)
//  writeVal      out  REG_DATA            write data (registered)
//  xcpt_valid    out  1                   exception capture strobe (registered, 1-cycle pulse)
//  rmPC          out  PC_WIDTH            PC for rm0
//  rmAddr        out  XCPT_ADDR           address/cause for rm1
// BEHAVIOUR
//  - Reset (reset==0, async): FIFOs empty, starvation counters 0, writeEn=0, xcpt_valid=0,
//    dest_addr/writeVal/rmPC/rmAddr=0, src_ready all 1 after release.
//  - Enqueue: src_valid&src_ready on a clock edge pushes {dest,data,xcpt,pc,xaddr}.
//    src_ready is combinational from FIFO count only (count<FIFO_DEPTH); it never depends on
//    src_valid. A push to a full FIFO cannot occur; assert on it.
//  - Arbitration: candidates are sources with non-empty FIFOs. If any candidate has
//    starve_cnt==STARVE_LIMIT, the highest-index such source wins. Otherwise the
//    highest-index candidate wins. The winner pops its head in the same cycle.
//  - starve_cnt[i]: 0 when FIFO i is empty or i wins; +1 (saturating at STARVE_LIMIT) when
//    FIFO i is non-empty and i loses.
//  - Output register, loaded every cycle (1-cycle latency, grant -> outputs):
//    winner xcpt=0 -> writeEn=1, dest_addr/writeVal=head, xcpt_valid=0.
//    winner xcpt=1 -> writeEn=0, xcpt_valid=1, rmPC/rmAddr=head. dest_addr/writeVal hold.
//    no winner     -> writeEn=0, xcpt_valid=0, other outputs hold.
//  - Minimum push-to-writeEn latency is 2 cycles (push edge, grant/register edge). The
//    register file makes the value readable one cycle later.
//  - Simultaneous push and pop on the same FIFO are allowed, including when full: count is
//    unchanged. A FIFO that is full at a clock edge where it wins also reports src_ready=1 only
//    from the following cycle.
//  - flush=1 (synchronous): all FIFOs emptied, starve counters cleared, and no grant that
//    cycle, so writeEn/xcpt_valid are 0 next cycle. Pushes presented during flush are dropped.
//    An output already registered before flush still completes.
//  - Dest register 0 is written like any other; there is no special zero register here.
//  - Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is
//    log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  - soc.vh / shared package: wb_entry_t {dest, data, xcpt, pc, xaddr}, WB_SRC_ALU/MUL/MEM
//    index constants, reusing REG_FILE_ADDR_RANGE, REG_FILE_DATA_RANGE, PC_WIDTH and
//    REG_FILE_XCPT_ADDR_RANGE.
//  - Sub-module wb_fifo (parameterised sync FIFO of wb_entry_t with push/pop/flush/count),
//    instantiated NUM_SRC times. Arbiter, starvation counters and output register live in
//    wb_arbiter. Flops use the codebase reset-FF macro style.
// TESTING
//  1. Reset mid-traffic: fill all FIFOs, pull reset low -> outputs 0 immediately, src_ready=3'b111
//     after release, and no stale write appears.
//  2. Single ALU push {dest=5, data=32'hDEADBEEF} -> two edges later writeEn=1, dest_addr=5,
//     writeVal=DEADBEEF for exactly 1 cycle.
//  3. All three sources push in the same cycle (dest 1/2/3) -> writes in order MEM(3), MUL(2),
//     ALU(1) on consecutive cycles.
//  4. MEM streams continuously while ALU holds one entry, STARVE_LIMIT=8 -> ALU is written on
//     the 9th arbitration cycle, then MEM resumes.
//  5. MUL pushes xcpt=1, pc=0x100, xaddr=0x40 -> xcpt_valid pulses 1 cycle with rmPC=0x100,
//     rmAddr=0x40, and writeEn stays 0.
//  6. Fill ALU FIFO (src_ready=0), assert flush -> next cycle writeEn=0, src_ready=1, and
//     FIFO contents are never written.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types and constants for the writeback arbiter: register-file field
// widths, the buffered result entry, source index constants and a priority
// helper that returns the highest set bit of a source mask.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int NUM_SRC     = 3;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_DATA_W  = 32;
    localparam int PC_WIDTH    = 32;
    localparam int XCPT_ADDR_W = 32;

    // Source indices double as static priority: a higher index wins.
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MUL = 1;
    localparam int WB_SRC_MEM = 2;

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
    typedef logic [REG_DATA_W-1:0]  reg_data_t;
    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [XCPT_ADDR_W-1:0] xcpt_addr_t;
    typedef logic [SRC_W-1:0]       src_idx_t;

    typedef struct packed {
        reg_addr_t  dest;
        reg_data_t  data;
        logic       xcpt;
        pc_t        pc;
        xcpt_addr_t xaddr;
    } wb_entry_t;

    // Index of the highest set bit; 0 when the mask is empty, so callers
    // must qualify the result with |mask.
    function automatic src_idx_t highest_set(input logic [NUM_SRC-1:0] mask);
        src_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mask[i]) idx = src_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the per-source result handshake and the register-file write /
// exception capture port.
//   master : execution sources + register file (drive src_*, observe outputs)
//   slave  : the arbiter (accepts src_*, drives src_ready and write port)
// -----------------------------------------------------------------------------
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    // Source side
    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    reg_addr_t          src_dest  [NUM_SRC];
    reg_data_t          src_data  [NUM_SRC];
    logic [NUM_SRC-1:0] src_xcpt;
    pc_t                src_pc    [NUM_SRC];
    xcpt_addr_t         src_xaddr [NUM_SRC];

    // Register-file write and exception capture side
    logic       writeEn;
    reg_addr_t  dest_addr;
    reg_data_t  writeVal;
    logic       xcpt_valid;
    pc_t        rmPC;
    xcpt_addr_t rmAddr;

    modport master (
        output src_valid, src_dest, src_data, src_xcpt, src_pc, src_xaddr,
        input  src_ready, writeEn, dest_addr, writeVal, xcpt_valid, rmPC, rmAddr
    );

    modport slave (
        input  src_valid, src_dest, src_data, src_xcpt, src_pc, src_xaddr,
        output src_ready, writeEn, dest_addr, writeVal, xcpt_valid, rmPC, rmAddr
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t with push, pop and synchronous flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush_i     : empties the FIFO; push/pop in the same cycle are ignored
//   push_i      : write wdata_i at the tail
//   pop_i       : drop the head (ignored when empty)
//   wdata_i     : entry to push
//   rdata_o     : current head entry (valid when empty_o==0)
//   count_o     : occupancy, 0..DEPTH
//   empty_o     : count_o == 0
// Simultaneous push and pop leave the count unchanged, including when full.
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_entry_t              wdata_i,
    output wb_entry_t              rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic do_push, do_pop, full;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & ~empty_o;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which
    // entries are meaningful, so resetting the array would only add muxes.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Overflow guard: a push into a full FIFO is only legal alongside a pop.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(do_push && full && !do_pop));
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback stage in front of the register file. Each execution source
// (ALU, MUL, MEM) feeds its own wb_fifo; one head is granted per cycle and
// registered onto the register-file write port or the exception capture port.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous pipeline flush, discards all buffered results
//   bus_io     : wb_arbiter_if.slave -- source handshakes in, write port out
// Priority is static (highest index wins) except that a source which has
// lost STARVE_LIMIT consecutive arbitrations while non-empty is forced in.
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    wb_arbiter_if.slave   bus_io
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    // ---------------------------------------------------------------- FIFOs
    wb_entry_t          wdata [NUM_SRC];
    wb_entry_t          head  [NUM_SRC];
    logic [CNT_W-1:0]   count [NUM_SRC];
    logic [NUM_SRC-1:0] empty, ready, push, pop;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            wdata[i] = '{dest:  bus_io.src_dest[i],
                         data:  bus_io.src_data[i],
                         xcpt:  bus_io.src_xcpt[i],
                         pc:    bus_io.src_pc[i],
                         xaddr: bus_io.src_xaddr[i]};
            // Ready depends on occupancy only, never on src_valid.
            ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
            push[i]  = bus_io.src_valid[i] & ready[i];
        end
    end

    assign bus_io.src_ready = ready;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush_i),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .wdata_i (wdata[g]),
            .rdata_o (head[g]),
            .count_o (count[g]),
            .empty_o (empty[g])
        );
    end

    // ---------------------------------------------------------- arbitration
    logic [STARVE_W-1:0] starve_cnt_q [NUM_SRC];
    logic [STARVE_W-1:0] starve_cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0]  cand, starving;
    logic                grant_valid;
    src_idx_t            win_idx;
    wb_entry_t           win_entry;

    always_comb begin
        cand     = ~empty;
        starving = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            starving[i] = cand[i] && (starve_cnt_q[i] == STARVE_W'(STARVE_LIMIT));
        end

        // Flush suppresses the grant so nothing reaches the write port.
        grant_valid = (|cand) && !flush_i;
        win_idx     = (|starving) ? highest_set(starving) : highest_set(cand);
        win_entry   = head[win_idx];

        pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = grant_valid && (win_idx == src_idx_t'(i));
        end

        for (int i = 0; i < NUM_SRC; i++) begin
            if (flush_i || !cand[i] || pop[i]) begin
                starve_cnt_d[i] = '0;
            end else if (starve_cnt_q[i] != STARVE_W'(STARVE_LIMIT)) begin
                starve_cnt_d[i] = starve_cnt_q[i] + STARVE_W'(1);
            end else begin
                starve_cnt_d[i] = starve_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) starve_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) starve_cnt_q[i] <= starve_cnt_d[i];
        end
    end

    // ------------------------------------------------------ output register
    logic       write_en_q,   write_en_d;
    reg_addr_t  dest_addr_q,  dest_addr_d;
    reg_data_t  write_val_q,  write_val_d;
    logic       xcpt_valid_q, xcpt_valid_d;
    pc_t        rm_pc_q,      rm_pc_d;
    xcpt_addr_t rm_addr_q,    rm_addr_d;

    // Strobes fall every cycle; address/data fields hold until overwritten.
    always_comb begin
        write_en_d   = 1'b0;
        xcpt_valid_d = 1'b0;
        dest_addr_d  = dest_addr_q;
        write_val_d  = write_val_q;
        rm_pc_d      = rm_pc_q;
        rm_addr_d    = rm_addr_q;
        if (grant_valid) begin
            if (win_entry.xcpt) begin
                xcpt_valid_d = 1'b1;
                rm_pc_d      = win_entry.pc;
                rm_addr_d    = win_entry.xaddr;
            end else begin
                write_en_d  = 1'b1;
                dest_addr_d = win_entry.dest;
                write_val_d = win_entry.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_q   <= 1'b0;
            dest_addr_q  <= '0;
            write_val_q  <= '0;
            xcpt_valid_q <= 1'b0;
            rm_pc_q      <= '0;
            rm_addr_q    <= '0;
        end else begin
            write_en_q   <= write_en_d;
            dest_addr_q  <= dest_addr_d;
            write_val_q  <= write_val_d;
            xcpt_valid_q <= xcpt_valid_d;
            rm_pc_q      <= rm_pc_d;
            rm_addr_q    <= rm_addr_d;
        end
    end

    assign bus_io.writeEn    = write_en_q;
    assign bus_io.dest_addr  = dest_addr_q;
    assign bus_io.writeVal   = write_val_q;
    assign bus_io.xcpt_valid = xcpt_valid_q;
    assign bus_io.rmPC       = rm_pc_q;
    assign bus_io.rmAddr     = rm_addr_q;

endmodule
